// File: rtl/switch_pkg.sv
// Shared switch-core definitions: MAC type, header geometry and learner FSM states.
package switch_pkg;
  typedef logic [47:0] mac_address_t;

  localparam int HEADER_BYTES = 12;
  localparam mac_address_t BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOOKUP,
    RESPOND,
    DRAIN
  } learner_state_t;

  // I/G bit: LSB of the first transmitted octet.
  function automatic logic is_group_address(input mac_address_t mac);
    return mac[40];
  endfunction
endpackage

// File: rtl/mac_table_cam.sv
// Learned MAC table: two parallel exact-match searches plus one write port.
// Search results are combinational on the current contents; writes land at the clock edge.
module mac_table_cam
  import switch_pkg::*;
#(
  parameter int TABLE_ENTRIES = 16,
  parameter int PORT_WIDTH    = 1,
  parameter int INDEX_WIDTH   = $clog2(TABLE_ENTRIES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  mac_address_t           key_a,
  input  mac_address_t           key_b,
  input  logic                   write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  mac_address_t           write_mac,
  input  logic [PORT_WIDTH-1:0]  write_port,
  output logic                   hit_a,
  output logic [PORT_WIDTH-1:0]  port_a,
  output logic                   hit_b,
  output logic [INDEX_WIDTH-1:0] index_b,
  output logic [INDEX_WIDTH-1:0] free_index,
  output logic                   full
);
  logic [TABLE_ENTRIES-1:0] valid_q, valid_d;
  mac_address_t             mac_q  [TABLE_ENTRIES];
  mac_address_t             mac_d  [TABLE_ENTRIES];
  logic [PORT_WIDTH-1:0]    port_q [TABLE_ENTRIES];
  logic [PORT_WIDTH-1:0]    port_d [TABLE_ENTRIES];

  always_comb begin
    valid_d = valid_q;
    mac_d   = mac_q;
    port_d  = port_q;
    if (write_enable) begin
      valid_d[write_index] = 1'b1;
      mac_d[write_index]   = write_mac;
      port_d[write_index]  = write_port;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      mac_q   <= mac_d;
      port_q  <= port_d;
    end
  end

  // Scan downwards so the lowest matching / free index wins.
  always_comb begin
    hit_a      = 1'b0;
    port_a     = '0;
    hit_b      = 1'b0;
    index_b    = '0;
    free_index = '0;
    for (int i = TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && mac_q[i] == key_a) begin
        hit_a  = 1'b1;
        port_a = port_q[i];
      end
      if (valid_q[i] && mac_q[i] == key_b) begin
        hit_b   = 1'b1;
        index_b = INDEX_WIDTH'(i);
      end
      if (!valid_q[i]) free_index = INDEX_WIDTH'(i);
    end
  end

  assign full = &valid_q;
endmodule

// File: rtl/mac_address_learner.sv
// Snoops the 12-byte MAC header of each frame, learns src->port and returns a dest port mask
// two cycles after the 12th byte; input is stalled while the mask waits for destination_ready.
module mac_address_learner
  import switch_pkg::*;
#(
  parameter int NUMBER_OF_PORTS = 2,
  parameter int TABLE_ENTRIES   = 16,
  parameter int PORT_WIDTH      = $clog2(NUMBER_OF_PORTS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [8:0]                 frame_data,
  input  logic                       frame_data_valid,
  output logic                       frame_data_ready,
  input  logic [PORT_WIDTH-1:0]      frame_source_port,
  output logic [NUMBER_OF_PORTS-1:0] destination_port_mask,
  output logic                       destination_valid,
  input  logic                       destination_ready,
  output logic [15:0]                runt_count
);
  localparam int INDEX_WIDTH = $clog2(TABLE_ENTRIES);
  localparam int HDR_W       = 8 * HEADER_BYTES;

  learner_state_t             state_q, state_d;
  logic [3:0]                 byte_cnt_q, byte_cnt_d;
  logic [HDR_W-1:0]           header_q, header_d;
  logic                       eof_q, eof_d;
  logic                       ready_q, ready_d;
  logic                       dst_vld_q, dst_vld_d;
  logic [NUMBER_OF_PORTS-1:0] mask_q, mask_d;
  logic [15:0]                runt_q, runt_d;
  logic [INDEX_WIDTH-1:0]     victim_q, victim_d;

  mac_address_t               dst_mac, src_mac;
  logic                       dst_hit, src_hit, table_full, write_enable;
  logic [PORT_WIDTH-1:0]      dst_port;
  logic [INDEX_WIDTH-1:0]     src_index, free_index, write_index;
  logic [NUMBER_OF_PORTS-1:0] flood_mask, lookup_mask;
  logic [15:0]                runt_sat;
  logic                       accept, eof_in;

  assign dst_mac  = header_q[HDR_W-1 -: 48];
  assign src_mac  = header_q[47:0];
  assign accept   = frame_data_valid & ready_q;
  assign eof_in   = frame_data[8];
  assign runt_sat = (runt_q == 16'hFFFF) ? runt_q : runt_q + 16'd1;

  mac_table_cam #(
    .TABLE_ENTRIES(TABLE_ENTRIES),
    .PORT_WIDTH   (PORT_WIDTH)
  ) u_cam (
    .clock       (clock),
    .reset       (reset),
    .key_a       (dst_mac),
    .key_b       (src_mac),
    .write_enable(write_enable),
    .write_index (write_index),
    .write_mac   (src_mac),
    .write_port  (frame_source_port),
    .hit_a       (dst_hit),
    .port_a      (dst_port),
    .hit_b       (src_hit),
    .index_b     (src_index),
    .free_index  (free_index),
    .full        (table_full)
  );

  assign flood_mask = ~(NUMBER_OF_PORTS'(1) << frame_source_port);

  always_comb begin
    lookup_mask = flood_mask;
    if (!is_group_address(dst_mac) && dst_hit)
      lookup_mask = (dst_port == frame_source_port) ? '0 : (NUMBER_OF_PORTS'(1) << dst_port);
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    header_d     = header_q;
    eof_d        = eof_q;
    dst_vld_d    = dst_vld_q;
    mask_d       = mask_q;
    runt_d       = runt_q;
    victim_d     = victim_q;
    write_enable = 1'b0;
    write_index  = victim_q;
    case (state_q)
      IDLE: if (accept) begin
        header_d   = {header_q[HDR_W-9:0], frame_data[7:0]};
        byte_cnt_d = 4'd1;
        if (eof_in) runt_d = runt_sat;
        else        state_d = HEADER;
      end
      HEADER: if (accept) begin
        header_d   = {header_q[HDR_W-9:0], frame_data[7:0]};
        byte_cnt_d = byte_cnt_q + 4'd1;
        if (byte_cnt_q == 4'(HEADER_BYTES - 1)) begin
          eof_d   = eof_in;
          state_d = LOOKUP;
        end else if (eof_in) begin
          runt_d  = runt_sat;
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        mask_d    = lookup_mask;
        dst_vld_d = 1'b1;
        state_d   = RESPOND;
        // Group source addresses are never learned; a full-table miss evicts round-robin.
        if (!is_group_address(src_mac)) begin
          write_enable = 1'b1;
          if (src_hit)          write_index = src_index;
          else if (!table_full) write_index = free_index;
          else                  victim_d    = victim_q + 1'b1;
        end
      end
      RESPOND: if (destination_ready) begin
        dst_vld_d = 1'b0;
        state_d   = eof_q ? IDLE : DRAIN;
      end
      DRAIN: if (accept && eof_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == HEADER) || (state_d == DRAIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      header_q   <= '0;
      eof_q      <= 1'b0;
      ready_q    <= 1'b0;
      dst_vld_q  <= 1'b0;
      mask_q     <= '0;
      runt_q     <= '0;
      victim_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      header_q   <= header_d;
      eof_q      <= eof_d;
      ready_q    <= ready_d;
      dst_vld_q  <= dst_vld_d;
      mask_q     <= mask_d;
      runt_q     <= runt_d;
      victim_q   <= victim_d;
    end
  end

  assign frame_data_ready      = ready_q;
  assign destination_valid     = dst_vld_q;
  assign destination_port_mask = mask_q;
  assign runt_count            = runt_q;
endmodule

// File: tb/tb_mac_address_learner.sv
// Bench for mac_address_learner: directed vector table, corner-case sequences and random frames
// checked against a table-level model of the learning and forwarding rules.
module tb_mac_address_learner;
  localparam int NP = 2;
  localparam int TE = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  frame_data = '0;
  logic        frame_data_valid = 1'b0;
  logic        frame_data_ready;
  logic [0:0]  frame_source_port = '0;
  logic [1:0]  destination_port_mask;
  logic        destination_valid;
  logic        destination_ready = 1'b0;
  logic [15:0] runt_count;

  always #5 clock = ~clock;

  mac_address_learner #(.NUMBER_OF_PORTS(NP), .TABLE_ENTRIES(TE)) dut (
    .clock                (clock),
    .reset                (reset),
    .frame_data           (frame_data),
    .frame_data_valid     (frame_data_valid),
    .frame_data_ready     (frame_data_ready),
    .frame_source_port    (frame_source_port),
    .destination_port_mask(destination_port_mask),
    .destination_valid    (destination_valid),
    .destination_ready    (destination_ready),
    .runt_count           (runt_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cur_frame = 0;
  bit gaps_on = 0;

  // Reference table: list of learned (mac, port) slots plus replacement pointer.
  bit          m_valid [TE];
  logic [47:0] m_mac   [TE];
  int          m_port  [TE];
  int          m_victim;
  int          m_runts;

  typedef struct {
    int          port;
    logic [47:0] dst;
    logic [47:0] src;
    int          len;
    int          hold;
    logic [1:0]  exp_mask;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (frame %0d): got %0h, expected %0h", name, cur_frame, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TE; i++) begin
      m_valid[i] = 0;
      m_mac[i]   = '0;
      m_port[i]  = 0;
    end
    m_victim = 0;
    m_runts  = 0;
  endtask

  task automatic model_frame(input int sp, input logic [47:0] dst, input logic [47:0] src,
                             output logic [1:0] mask);
    int d_idx, s_idx, free, w;
    logic [1:0] flood;
    d_idx = -1; s_idx = -1; free = -1;
    flood = 2'b11 & ~(2'b01 << sp);
    for (int i = 0; i < TE; i++) begin
      if (m_valid[i]) begin
        if (m_mac[i] == dst && d_idx < 0) d_idx = i;
        if (m_mac[i] == src && s_idx < 0) s_idx = i;
      end else if (free < 0) free = i;
    end
    if (dst[40] || d_idx < 0)       mask = flood;
    else if (m_port[d_idx] == sp)   mask = 2'b00;
    else                            mask = 2'b01 << m_port[d_idx];
    if (!src[40]) begin
      if (s_idx >= 0)     w = s_idx;
      else if (free >= 0) w = free;
      else begin
        w = m_victim;
        m_victim = (m_victim + 1) % TE;
      end
      m_valid[w] = 1;
      m_mac[w]   = src;
      m_port[w]  = sp;
    end
  endtask

  function automatic logic [7:0] hdr_byte(input logic [47:0] dst, input logic [47:0] src, input int i);
    if (i < 6) return dst[47 - 8*i -: 8];
    return src[47 - 8*(i-6) -: 8];
  endfunction

  // Called and returns on a falling edge; the byte is accepted on the rising edge in between.
  task automatic push_byte(input logic [7:0] d, input bit eof);
    int t;
    t = 0;
    if (gaps_on && $urandom_range(0, 3) == 0) begin
      frame_data_valid = 1'b0;
      frame_data = {1'b1, 8'($urandom)};
      repeat ($urandom_range(1, 2)) @(negedge clock);
    end
    frame_data = {eof, d};
    frame_data_valid = 1'b1;
    while (frame_data_ready !== 1'b1 && t < 64) begin
      @(negedge clock);
      t++;
    end
    if (frame_data_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept_timeout (frame %0d): ready=%b after %0d cycles, expected 1", cur_frame, frame_data_ready, t);
    end
    @(negedge clock);
    frame_data_valid = 1'b0;
  endtask

  task automatic send_frame(input int sp, input logic [47:0] dst, input logic [47:0] src,
                            input int len, input int hold, input logic [1:0] exp_mask);
    cur_frame++;
    frame_source_port = sp[0];
    destination_ready = gaps_on ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int i = 0; i < 12; i++) push_byte(hdr_byte(dst, src, i), (len == 12) && (i == 11));
    destination_ready = 1'b0;
    check("valid_at_n+1", destination_valid, 0);
    check("ready_in_lookup", frame_data_ready, 0);
    @(negedge clock);
    check("valid_at_n+2", destination_valid, 1);
    check("mask", destination_port_mask, exp_mask);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", destination_valid, 1);
      check("hold_mask", destination_port_mask, exp_mask);
      check("hold_ready", frame_data_ready, 0);
    end
    destination_ready = 1'b1;
    @(negedge clock);
    destination_ready = 1'b0;
    check("valid_drop", destination_valid, 0);
    for (int i = 12; i < len; i++) push_byte(8'($urandom), i == len - 1);
  endtask

  task automatic send_model_frame(input int sp, input logic [47:0] dst, input logic [47:0] src,
                                  input int len, input int hold);
    logic [1:0] m;
    model_frame(sp, dst, src, m);
    send_frame(sp, dst, src, len, hold, m);
  endtask

  task automatic send_runt(input int len);
    cur_frame++;
    for (int i = 0; i < len; i++) push_byte(8'($urandom), i == len - 1);
    @(negedge clock);
    if (m_runts < 65535) m_runts++;
    check("runt_no_valid", destination_valid, 0);
    check("runt_count", runt_count, m_runts);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, frame_data_ready, 0);
    check({tag, "_valid"}, destination_valid, 0);
    check({tag, "_mask"}, destination_port_mask, 0);
    check({tag, "_runt"}, runt_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  localparam logic [47:0] MC_SRC = 48'h01_00_5E_00_00_01;

  initial begin
    logic [1:0] unused_mask;
    logic [47:0] dst, src;
    int r;

    vecs[0] = '{0, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_AA, 64, 0,  2'b10};
    vecs[1] = '{1, 48'h02_00_00_00_00_AA, 48'h02_00_00_00_00_BB, 20, 0,  2'b01};
    vecs[2] = '{0, 48'h02_00_00_00_00_AA, 48'h02_00_00_00_00_CC, 16, 1,  2'b00};
    vecs[3] = '{1, 48'hFF_FF_FF_FF_FF_FF, MC_SRC,                14, 0,  2'b01};
    vecs[4] = '{0, 48'h02_00_00_00_00_BB, 48'h02_00_00_00_00_DD, 12, 10, 2'b10};
    vecs[5] = '{1, 48'h02_00_00_00_00_DD, 48'h02_00_00_00_00_EE, 13, 2,  2'b01};

    @(negedge clock);
    do_reset();

    foreach (vecs[i]) begin
      model_frame(vecs[i].port, vecs[i].dst, vecs[i].src, unused_mask);
      send_frame(vecs[i].port, vecs[i].dst, vecs[i].src, vecs[i].len, vecs[i].hold, vecs[i].exp_mask);
    end

    send_runt(8);
    send_runt(1);
    model_frame(0, 48'h02_00_00_00_00_EE, 48'h02_00_00_00_00_11, unused_mask);
    send_frame(0, 48'h02_00_00_00_00_EE, 48'h02_00_00_00_00_11, 20, 0, 2'b10);

    // Fill the empty table with 17 sources; the last one must evict entry 0.
    do_reset();
    for (int x = 0; x < 17; x++) begin
      model_frame(0, 48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_01_00 | 48'(x), unused_mask);
      send_frame(0, 48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_01_00 | 48'(x), 12, 0, 2'b10);
    end
    model_frame(0, 48'h02_00_00_00_01_01, MC_SRC, unused_mask);
    send_frame(0, 48'h02_00_00_00_01_01, MC_SRC, 12, 0, 2'b00);
    model_frame(0, 48'h02_00_00_00_01_10, MC_SRC, unused_mask);
    send_frame(0, 48'h02_00_00_00_01_10, MC_SRC, 12, 0, 2'b00);
    model_frame(0, 48'h02_00_00_00_01_00, MC_SRC, unused_mask);
    send_frame(0, 48'h02_00_00_00_01_00, MC_SRC, 12, 0, 2'b10);
    send_runt(3);

    // Reset in the middle of a header: outputs drop immediately and the table is emptied.
    cur_frame++;
    for (int i = 0; i < 5; i++) push_byte(8'h02, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("midframe_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_frame(0, 48'h02_00_00_00_01_01, MC_SRC, unused_mask);
    send_frame(0, 48'h02_00_00_00_01_01, MC_SRC, 12, 0, 2'b10);

    gaps_on = 1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_runt($urandom_range(1, 11));
      end else begin
        dst = ($urandom_range(0, 9) == 0) ? 48'hFF_FF_FF_FF_FF_FF : 48'h02_00_00_00_00_00 | 48'($urandom_range(0, 19));
        src = ($urandom_range(0, 9) == 0) ? MC_SRC : 48'h02_00_00_00_00_00 | 48'($urandom_range(0, 19));
        send_model_frame($urandom_range(0, 1), dst, src, $urandom_range(12, 24), $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
